wishbone_arbiter_2m: RTL and testbench
======================================

// Module: wishbone_arbiter_2m
// PURPOSE
// - Shares one Wishbone slave bus between two Wishbone masters: M0 is the picobus-Wishbone bridge, M1 is a secondary master (DMA/debug).
// - Registered round-robin grant held for the whole bus cycle (CYC). Request/response signals are muxed combinationally to and from the granted master.
// - Optional watchdog terminates stalled slave cycles with an error.
// PARAMETERS
// - ADR_W           22   Wishbone address width
// - DAT_W           32   Wishbone data width; SEL width = DAT_W/8
// - TIMEOUT_CYCLES  64   stalled-STB cycles before forced error (WB_ARB_TIMEOUT_EN only)
// PORTS
// - in_clock        in   1       single clock; all state updates on rising edge
// - in_reset_n      in   1       synchronous, active-low reset
// - in_mX_cyc       in   1       master X (X=0,1) bus cycle request
// - in_mX_stb       in   1       master X strobe
// - in_mX_we        in   1       master X write enable
// - in_mX_adr       in   ADR_W   master X address
// - in_mX_sel       in   DAT_W/8 master X byte select
// - in_mX_wdat      in   DAT_W   master X write data
// - out_mX_ack      out  1       ack to master X (granted master only)
// - out_mX_err      out  1       err to master X (granted master only)
// - out_mX_rdat     out  DAT_W   read data to master X (broadcast of in_wb_rdat)
// - out_wb_cyc/stb/we  out 1     slave-side controls
// - out_wb_adr      out  ADR_W   slave address
// - out_wb_sel      out  DAT_W/8 slave byte select
// - out_wb_wdat     out  DAT_W   slave write data
// - in_wb_ack/err   in   1       slave termination
// - in_wb_rdat      in   DAT_W   slave read data
// - out_grant       out  2       one-hot grant {M1,M0}; 2'b00 = idle
// BEHAVIOUR
// - Reset (in_reset_n=0 at edge): state=IDLE, out_grant=00, last_served=M1 (M0 wins the first tie), timeout counter=0.
// - Consequence of reset: all out_wb_* = 0, and out_mX_ack/err = 0. out_mX_rdat follows in_wb_rdat at all times.
// - FSM IDLE / GNT0 / GNT1:
//   - IDLE: exactly one cyc high -> grant that master. Both high -> grant the master != last_served. No cyc -> stay.
//   - GNTx: stay while in_mx_cyc=1. in_mx_cyc=0 -> IDLE and last_served=x.
//   - Always exactly one IDLE cycle between grants, even when the other master is waiting.
// - Latency: cyc rises in cycle N -> grant registered at edge ending N -> out_wb_cyc/stb visible in cycle N+1.
// - In GNTx, all out_wb_* equal master x's inputs combinationally. In IDLE, all out_wb_* are forced to 0.
// - out_mx_ack = in_wb_ack & !in_wb_err, granted x only. out_mx_err = in_wb_err, granted x only.
// - The non-granted master always sees ack=err=0, and its stb is ignored.
// - Slave ack and err in the same cycle: err wins, ack suppressed.
// - Granted master drops cyc mid-transfer (abort): out_wb_cyc falls in the same cycle, FSM -> IDLE next edge, late ack/err not forwarded.
// - Grant never changes while the granted master holds cyc. Pipelined/back-to-back stb within one cyc is allowed.
// CONFIGURATION
// - WB_ARB_TIMEOUT_EN defined:
//   - Counter increments each cycle with out_wb_stb=1 and no in_wb_ack/in_wb_err.
//   - Counter clears on ack, err, stb low, or grant change.
//   - Counter == TIMEOUT_CYCLES-1 with no termination -> out_mx_err=1 to granted master for that one cycle, counter clears.
//   - A slave ack arriving in that same cycle is suppressed.
// - WB_ARB_TIMEOUT_EN undefined: no counter, TIMEOUT_CYCLES unused, stalled cycles hang indefinitely.
// TESTING
// - Reset: hold in_reset_n=0 with both cyc=1 -> out_grant=00, out_wb_cyc=0, no ack/err.
// - M0-only read: m0 cyc/stb, adr=22'h000024, we=0, slave ack with rdat=32'hDAFA two cycles later.
//   -> out_grant=01 one cycle after request; out_m0_ack=1 with out_m0_rdat=32'hDAFA; out_m1_ack=0.
// - Contention: both cyc high from the same edge after reset.
//   -> M0 granted first. M0 drops cyc -> one IDLE cycle -> M1 granted.
//   -> Repeat contention -> M0 granted again (round-robin).
// - Write passthrough: M1 granted, we=1, sel=4'b0011, wdat=32'h0000DAFA.
//   -> out_wb_we=1, out_wb_sel=0011, out_wb_wdat=32'h0000DAFA in the same cycle.
// - Simultaneous in_wb_ack=1 and in_wb_err=1 while M0 granted -> out_m0_err=1, out_m0_ack=0.
//   Abort: M0 drops cyc before ack -> out_wb_cyc=0 same cycle, grant 00 next edge.
// - WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never responds
//   -> out_m0_err pulses exactly once, on the 8th stb cycle.
//   -> Without the macro, no err for 100 cycles.

Source files
------------

// File: rtl/wishbone_arbiter_2m.sv
// Two-master Wishbone arbiter: registered round-robin grant held for a whole CYC.
// Optional stalled-cycle watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wishbone_arbiter_2m #(
    parameter int unsigned ADR_W          = 22,
    parameter int unsigned DAT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic               in_clock,
    input  logic               in_reset_n,
    // master 0
    input  logic               in_m0_cyc,
    input  logic               in_m0_stb,
    input  logic               in_m0_we,
    input  logic [ADR_W-1:0]   in_m0_adr,
    input  logic [DAT_W/8-1:0] in_m0_sel,
    input  logic [DAT_W-1:0]   in_m0_wdat,
    output logic               out_m0_ack,
    output logic               out_m0_err,
    output logic [DAT_W-1:0]   out_m0_rdat,
    // master 1
    input  logic               in_m1_cyc,
    input  logic               in_m1_stb,
    input  logic               in_m1_we,
    input  logic [ADR_W-1:0]   in_m1_adr,
    input  logic [DAT_W/8-1:0] in_m1_sel,
    input  logic [DAT_W-1:0]   in_m1_wdat,
    output logic               out_m1_ack,
    output logic               out_m1_err,
    output logic [DAT_W-1:0]   out_m1_rdat,
    // slave side
    output logic               out_wb_cyc,
    output logic               out_wb_stb,
    output logic               out_wb_we,
    output logic [ADR_W-1:0]   out_wb_adr,
    output logic [DAT_W/8-1:0] out_wb_sel,
    output logic [DAT_W-1:0]   out_wb_wdat,
    input  logic               in_wb_ack,
    input  logic               in_wb_err,
    input  logic [DAT_W-1:0]   in_wb_rdat,
    output logic [1:0]         out_grant
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end
    if ((DAT_W % 8) != 0) begin : g_bad_dat_w
        $error("DAT_W must be a multiple of 8");
    end

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StGnt0 = 2'b01,
        StGnt1 = 2'b10
    } state_e;

    state_e state_q, state_d;
    // 1'b0 = M0 served last, 1'b1 = M1 served last
    logic   last_served_q, last_served_d;
    logic   timeout_hit;
    logic   fwd_ack, fwd_err;

    // ---------------------------------------------------------------- grant FSM
    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        unique case (state_q)
            StIdle: begin
                if (in_m0_cyc && in_m1_cyc) begin
                    state_d = last_served_q ? StGnt0 : StGnt1;
                end else if (in_m0_cyc) begin
                    state_d = StGnt0;
                end else if (in_m1_cyc) begin
                    state_d = StGnt1;
                end
            end
            StGnt0: begin
                if (!in_m0_cyc) begin
                    state_d       = StIdle;
                    last_served_d = 1'b0;
                end
            end
            StGnt1: begin
                if (!in_m1_cyc) begin
                    state_d       = StIdle;
                    last_served_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge in_clock) begin
        if (!in_reset_n) begin
            state_q       <= StIdle;
            last_served_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
        end
    end

    assign out_grant = {state_q == StGnt1, state_q == StGnt0};

    // --------------------------------------------------------- request muxing
    always_comb begin
        out_wb_cyc  = 1'b0;
        out_wb_stb  = 1'b0;
        out_wb_we   = 1'b0;
        out_wb_adr  = '0;
        out_wb_sel  = '0;
        out_wb_wdat = '0;
        unique case (state_q)
            StGnt0: begin
                out_wb_cyc  = in_m0_cyc;
                out_wb_stb  = in_m0_stb;
                out_wb_we   = in_m0_we;
                out_wb_adr  = in_m0_adr;
                out_wb_sel  = in_m0_sel;
                out_wb_wdat = in_m0_wdat;
            end
            StGnt1: begin
                out_wb_cyc  = in_m1_cyc;
                out_wb_stb  = in_m1_stb;
                out_wb_we   = in_m1_we;
                out_wb_adr  = in_m1_adr;
                out_wb_sel  = in_m1_sel;
                out_wb_wdat = in_m1_wdat;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- watchdog
`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign timeout_hit = out_wb_stb && !in_wb_err && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if (out_wb_stb && !in_wb_ack && !in_wb_err && !timeout_hit && (state_d == state_q)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge in_clock) begin
        if (!in_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // -------------------------------------------------------- response routing
    // Gating by out_wb_cyc drops late terminations after an abort.
    assign fwd_ack = out_wb_cyc & in_wb_ack & ~in_wb_err & ~timeout_hit;
    assign fwd_err = out_wb_cyc & (in_wb_err | timeout_hit);

    assign out_m0_ack  = fwd_ack & (state_q == StGnt0);
    assign out_m0_err  = fwd_err & (state_q == StGnt0);
    assign out_m1_ack  = fwd_ack & (state_q == StGnt1);
    assign out_m1_err  = fwd_err & (state_q == StGnt1);
    assign out_m0_rdat = in_wb_rdat;
    assign out_m1_rdat = in_wb_rdat;

endmodule

// File: tb/tb_wishbone_arbiter_2m.sv
// Self-checking bench for wishbone_arbiter_2m: directed spec scenarios followed by
// randomized traffic compared against an ownership-based reference model.
module tb_wishbone_arbiter_2m;

    localparam int unsigned ADR_W = 22;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned TO    = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [ADR_W-1:0]   m0_adr, m1_adr;
    logic [DAT_W/8-1:0] m0_sel, m1_sel;
    logic [DAT_W-1:0]   m0_wdat, m1_wdat;
    logic               m0_ack, m0_err, m1_ack, m1_err;
    logic [DAT_W-1:0]   m0_rdat, m1_rdat;
    logic               wb_cyc, wb_stb, wb_we;
    logic [ADR_W-1:0]   wb_adr;
    logic [DAT_W/8-1:0] wb_sel;
    logic [DAT_W-1:0]   wb_wdat;
    logic               wb_ack, wb_err;
    logic [DAT_W-1:0]   wb_rdat;
    logic [1:0]         grant;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the bus (0 none, 1 M0, 2 M1) and who was served last.
    int owner = 0;
    int last  = 2;
    int tcnt  = 0;

    always #5 clk = ~clk;

    wishbone_arbiter_2m #(
        .ADR_W         (ADR_W),
        .DAT_W         (DAT_W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .in_clock   (clk),
        .in_reset_n (rst_n),
        .in_m0_cyc  (m0_cyc),
        .in_m0_stb  (m0_stb),
        .in_m0_we   (m0_we),
        .in_m0_adr  (m0_adr),
        .in_m0_sel  (m0_sel),
        .in_m0_wdat (m0_wdat),
        .out_m0_ack (m0_ack),
        .out_m0_err (m0_err),
        .out_m0_rdat(m0_rdat),
        .in_m1_cyc  (m1_cyc),
        .in_m1_stb  (m1_stb),
        .in_m1_we   (m1_we),
        .in_m1_adr  (m1_adr),
        .in_m1_sel  (m1_sel),
        .in_m1_wdat (m1_wdat),
        .out_m1_ack (m1_ack),
        .out_m1_err (m1_err),
        .out_m1_rdat(m1_rdat),
        .out_wb_cyc (wb_cyc),
        .out_wb_stb (wb_stb),
        .out_wb_we  (wb_we),
        .out_wb_adr (wb_adr),
        .out_wb_sel (wb_sel),
        .out_wb_wdat(wb_wdat),
        .in_wb_ack  (wb_ack),
        .in_wb_err  (wb_err),
        .in_wb_rdat (wb_rdat),
        .out_grant  (grant)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_cyc();
        return (owner == 1) ? m0_cyc : (owner == 2) ? m1_cyc : 1'b0;
    endfunction

    function automatic logic exp_stb();
        return (owner == 1) ? m0_stb : (owner == 2) ? m1_stb : 1'b0;
    endfunction

    function automatic logic exp_hit();
`ifdef WB_ARB_TIMEOUT_EN
        return exp_stb() && !wb_err && (tcnt == TO - 1);
`else
        return 1'b0;
`endif
    endfunction

    // Compare every DUT output against the model for the current inputs.
    task automatic check_all(input string tag);
        logic we, ack, err;
        logic [ADR_W-1:0] adr;
        logic [DAT_W/8-1:0] sel;
        logic [DAT_W-1:0] wdat;
        #1;
        we = 1'b0; adr = '0; sel = '0; wdat = '0;
        if (owner == 1) begin
            we = m0_we; adr = m0_adr; sel = m0_sel; wdat = m0_wdat;
        end else if (owner == 2) begin
            we = m1_we; adr = m1_adr; sel = m1_sel; wdat = m1_wdat;
        end
        ack = exp_cyc() && wb_ack && !wb_err && !exp_hit();
        err = exp_cyc() && (wb_err || exp_hit());
        check({tag, ".grant"}, grant, (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00);
        check({tag, ".wb_cyc"}, wb_cyc, exp_cyc());
        check({tag, ".wb_stb"}, wb_stb, exp_stb());
        check({tag, ".wb_we"}, wb_we, we);
        check({tag, ".wb_adr"}, wb_adr, adr);
        check({tag, ".wb_sel"}, wb_sel, sel);
        check({tag, ".wb_wdat"}, wb_wdat, wdat);
        check({tag, ".m0_ack"}, m0_ack, ack && owner == 1);
        check({tag, ".m0_err"}, m0_err, err && owner == 1);
        check({tag, ".m1_ack"}, m1_ack, ack && owner == 2);
        check({tag, ".m1_err"}, m1_err, err && owner == 2);
        check({tag, ".m0_rdat"}, m0_rdat, wb_rdat);
        check({tag, ".m1_rdat"}, m1_rdat, wb_rdat);
    endtask

    // Advance the model across one rising edge, then the clock itself.
    task automatic advance();
        int nxt;
        logic hit;
        hit = exp_hit();
        nxt = owner;
        if (!rst_n) begin
            nxt = 0; last = 2;
        end else if (owner == 0) begin
            if (m0_cyc && m1_cyc) nxt = (last == 2) ? 1 : 2;
            else if (m0_cyc) nxt = 1;
            else if (m1_cyc) nxt = 2;
        end else if (!exp_cyc()) begin
            last = owner; nxt = 0;
        end
        if (!rst_n || nxt != owner || !exp_stb() || wb_ack || wb_err || hit) tcnt = 0;
        else tcnt++;
        owner = nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_sel = '0; m0_wdat = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_sel = '0; m1_wdat = '0;
        wb_ack = 0; wb_err = 0; wb_rdat = '0;
    endtask

    initial begin
        int err_cnt;
        int err_at;

        // Reset held with both masters requesting
        idle_inputs();
        rst_n = 0;
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        advance();
        advance();
        check_all("reset");
        check("reset.grant_const", grant, 2'b00);
        check("reset.wb_cyc_const", wb_cyc, 1'b0);
        check("reset.acks", {m0_ack, m0_err, m1_ack, m1_err}, 4'b0000);

        // M0-only read
        idle_inputs();
        rst_n = 1;
        advance();
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 22'h000024; m0_sel = 4'hF;
        check_all("rd.req");
        advance();
        check_all("rd.gnt");
        check("rd.grant_const", grant, 2'b01);
        check("rd.adr_const", wb_adr, 22'h000024);
        advance();
        check_all("rd.wait");
        wb_ack = 1; wb_rdat = 32'hDAFA;
        check_all("rd.ack");
        check("rd.m0_ack_const", m0_ack, 1'b1);
        check("rd.m0_rdat_const", m0_rdat, 32'hDAFA);
        check("rd.m1_ack_const", m1_ack, 1'b0);
        advance();
        idle_inputs();
        check_all("rd.end");
        advance();

        // Contention straight out of reset
        rst_n = 0;
        advance();
        rst_n = 1;
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        advance();
        check_all("cont.first");
        check("cont.first_const", grant, 2'b01);
        m0_cyc = 0; m0_stb = 0;
        check_all("cont.drop0");
        advance();
        check_all("cont.idle");
        check("cont.idle_const", grant, 2'b00);
        advance();
        check("cont.second_const", grant, 2'b10);

        // Write passthrough from M1
        m1_we = 1; m1_sel = 4'b0011; m1_wdat = 32'h0000DAFA; m1_adr = 22'h3ABCD;
        check_all("wr");
        check("wr.we_const", wb_we, 1'b1);
        check("wr.sel_const", wb_sel, 4'b0011);
        check("wr.wdat_const", wb_wdat, 32'h0000DAFA);

        // Round-robin: M0 queued while M1 drops, then M1 asks again
        m1_cyc = 0; m1_stb = 0; m0_cyc = 1; m0_stb = 1;
        advance();
        m1_cyc = 1; m1_stb = 1;
        advance();
        check_all("rr");
        check("rr.grant_const", grant, 2'b01);

        // Simultaneous ack and err
        wb_ack = 1; wb_err = 1;
        check_all("ackerr");
        check("ackerr.pair", {m0_err, m0_ack}, 2'b10);

        // Abort with a late ack
        wb_err = 0; wb_ack = 0;
        advance();
        m0_cyc = 0; m0_stb = 0; wb_ack = 1;
        check_all("abort");
        check("abort.wb_cyc_const", wb_cyc, 1'b0);
        check("abort.m0_ack_const", m0_ack, 1'b0);
        advance();
        wb_ack = 0;
        check_all("abort.idle");
        check("abort.grant_const", grant, 2'b00);
        m1_cyc = 0; m1_stb = 0;
        advance();
        advance();

        // Stalled slave
        idle_inputs();
        m0_cyc = 1; m0_stb = 1;
        advance();
        err_cnt = 0;
        err_at  = 0;
`ifdef WB_ARB_TIMEOUT_EN
        for (int i = 1; i <= TO + 4; i++) begin
`else
        for (int i = 1; i <= 100; i++) begin
`endif
            check_all("stall");
            if (m0_err) begin
                err_cnt++;
                if (err_at == 0) err_at = i;
            end
            advance();
        end
`ifdef WB_ARB_TIMEOUT_EN
        check("stall.err_count", err_cnt, 1);
        check("stall.err_cycle", err_at, TO);
`else
        check("stall.err_count", err_cnt, 0);
`endif
        idle_inputs();
        advance();
        advance();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (m0_cyc) m0_cyc = ($urandom_range(99) >= 15);
            else        m0_cyc = ($urandom_range(99) < 30);
            if (m1_cyc) m1_cyc = ($urandom_range(99) >= 15);
            else        m1_cyc = ($urandom_range(99) < 30);
            m0_stb  = ($urandom_range(99) < 70);
            m1_stb  = ($urandom_range(99) < 70);
            m0_we   = 1'($urandom);
            m1_we   = 1'($urandom);
            m0_adr  = ADR_W'($urandom);
            m1_adr  = ADR_W'($urandom);
            m0_sel  = 4'($urandom);
            m1_sel  = 4'($urandom);
            m0_wdat = $urandom;
            m1_wdat = $urandom;
            wb_ack  = ($urandom_range(99) < 40);
            wb_err  = ($urandom_range(99) < 8);
            wb_rdat = $urandom;
            check_all("rand");
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
